// File: rtl/seq_event_logger.sv
// Timestamps each detection pulse into a small FWFT FIFO, with a saturating
// detection count and a sticky flag for events lost while the FIFO was full.
module seq_event_logger #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       detected,
  input  logic                       rd_en,
  output logic [TS_WIDTH-1:0]        rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_WIDTH-1:0]       event_count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [LW-1:0]       level_q;
  logic                pop;
  logic                push;
  logic                drop;
  logic                is_full;

  assign is_full = (level_q == LW'(DEPTH));
  assign pop     = rd_en & (level_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push    = detected & (~is_full | pop);
  assign drop    = detected & is_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      event_count <= '0;
      overflow    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      ts          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      event_count <= '0;
      overflow    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
      if (push) begin
        mem[wr_ptr] <= ts;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
      if (drop) overflow <= 1'b1;
      if (detected && (event_count != '1)) event_count <= event_count + CNT_WIDTH'(1);
    end
  end

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (level_q != '0);
  assign full     = is_full;
  assign level    = level_q;

endmodule

// File: tb/tb_seq_event_logger.sv
// Self-checking bench: fixed vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_seq_event_logger;

  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 255;
  localparam int TS_MOD  = 65536;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        detected = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic [2:0]  level;
  logic [7:0]  event_count;
  logic        overflow;

  seq_event_logger #(.TS_WIDTH(16), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .detected(detected), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .level(level),
    .event_count(event_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model
  int unsigned m_ts = 0;
  int          q[$];
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;

  typedef struct {
    logic det, rd, cl;
    int   lvl;
    logic vld;
    int   data;
    int   cnt;
    logic ovf;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_ts  = 0;
  endtask

  task automatic model_edge(input bit det, input bit rd, input bit cl);
    bit can_pop;
    bit was_full;
    if (cl) begin
      model_reset();
    end else begin
      can_pop  = rd && (q.size() > 0);
      was_full = (q.size() == DEPTH);
      if (can_pop) void'(q.pop_front());
      if (det) begin
        if (!was_full || can_pop) q.push_back(int'(m_ts));
        else m_ovf = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      m_ts = (m_ts + 1) % TS_MOD;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".event_count"}, 32'(event_count), 32'(m_cnt));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit det, input bit rd, input bit cl, input bit do_chk, input string tag);
    detected = det;
    rd_en    = rd;
    clr      = cl;
    @(posedge clk);
    model_edge(det, rd, cl);
    @(negedge clk);
    detected = 1'b0;
    rd_en    = 1'b0;
    clr      = 1'b0;
    if (do_chk) check_model(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  function automatic vec_t mk(input logic det, rd, cl, input int lvl, input logic vld,
                              input int data, input int cnt, input logic ovf);
    vec_t v;
    v.det = det; v.rd = rd; v.cl = cl; v.lvl = lvl; v.vld = vld;
    v.data = data; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    int exp_seq[4];
    int ts_set[5];
    bit hit;

    // Row 0 clears so timestamp 0 is sampled by row 1.
    tbl[0]  = mk(0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 1, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 0, 1, 0);
    tbl[3]  = mk(1, 0, 0, 2, 1, 0, 2, 0);
    tbl[4]  = mk(0, 1, 0, 1, 1, 2, 2, 0);
    tbl[5]  = mk(1, 1, 0, 1, 1, 4, 3, 0);
    tbl[6]  = mk(1, 0, 0, 2, 1, 4, 4, 0);
    tbl[7]  = mk(1, 0, 0, 3, 1, 4, 5, 0);
    tbl[8]  = mk(1, 0, 0, 4, 1, 4, 6, 0);
    tbl[9]  = mk(1, 0, 0, 4, 1, 4, 7, 1);
    tbl[10] = mk(1, 1, 0, 4, 1, 5, 8, 1);
    tbl[11] = mk(0, 1, 0, 3, 1, 6, 8, 1);
    tbl[12] = mk(0, 1, 0, 2, 1, 7, 8, 1);
    tbl[13] = mk(0, 1, 0, 1, 1, 9, 8, 1);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 8, 1);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 8, 1);
    tbl[16] = mk(1, 0, 1, 0, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.rd_valid", 32'(rd_valid), 0);
    chk("reset.level", 32'(level), 0);
    chk("reset.full", 32'(full), 0);
    chk("reset.rd_data", 32'(rd_data), 0);
    chk("reset.event_count", 32'(event_count), 0);
    chk("reset.overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    model_reset();

    // Idle 10 cycles, then the next push carries timestamp 10
    idle(10);
    check_model("idle10");
    step(1'b1, 1'b0, 1'b0, 1'b1, "idle10_push");
    chk("idle10.ts", 32'(rd_data), 10);

    // Vector table
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].det, tbl[i].rd, tbl[i].cl, 1'b1, "table");
      chk($sformatf("tbl%0d.level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d.full", i), 32'(full), 32'(tbl[i].lvl == DEPTH));
      chk($sformatf("tbl%0d.event_count", i), 32'(event_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.overflow", i), 32'(overflow), 32'(tbl[i].ovf));
      if (tbl[i].vld || tbl[i].cl)
        chk($sformatf("tbl%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].data));
    end

    // Single pulse at timestamp 5
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr");
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b1, "single");
    chk("single.rd_data", 32'(rd_data), 5);
    chk("single.level", 32'(level), 1);
    chk("single.event_count", 32'(event_count), 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, "single_pop");
    chk("single_pop.rd_valid", 32'(rd_valid), 0);

    // Pulses at 3,4,7,9,12: the last is dropped
    ts_set = '{3, 4, 7, 9, 12};
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr");
    for (int t = 0; t <= 12; t++) begin
      hit = 1'b0;
      foreach (ts_set[k]) if (ts_set[k] == t) hit = 1'b1;
      step(hit, 1'b0, 1'b0, 1'b0, "burst");
    end
    check_model("burst");
    chk("burst.full", 32'(full), 1);
    chk("burst.level", 32'(level), 4);
    chk("burst.overflow", 32'(overflow), 1);
    chk("burst.event_count", 32'(event_count), 5);
    exp_seq = '{3, 4, 7, 9};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d.rd_data", k), 32'(rd_data), 32'(exp_seq[k]));
      step(1'b0, 1'b1, 1'b0, 1'b1, "drain");
    end
    chk("drain.rd_valid", 32'(rd_valid), 0);

    // Full FIFO with simultaneous push and pop
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr");
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b1, "fill");
    step(1'b1, 1'b1, 1'b0, 1'b1, "full_pushpop");
    chk("full_pushpop.level", 32'(level), 4);
    chk("full_pushpop.overflow", 32'(overflow), 0);
    chk("full_pushpop.rd_data", 32'(rd_data), 1);

    // Counter saturation then clr racing a detection
    step(1'b0, 1'b0, 1'b1, 1'b1, "clr");
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 1'b0, 1'b0, "sat");
    check_model("sat");
    chk("sat.event_count", 32'(event_count), 255);
    step(1'b1, 1'b0, 1'b1, 1'b1, "clr_det");
    chk("clr_det.event_count", 32'(event_count), 0);
    chk("clr_det.level", 32'(level), 0);
    chk("clr_det.overflow", 32'(overflow), 0);
    chk("clr_det.rd_data", 32'(rd_data), 0);

    // Timestamp wrap
    idle(65535);
    step(1'b1, 1'b0, 1'b0, 1'b1, "wrap_a");
    step(1'b1, 1'b0, 1'b0, 1'b1, "wrap_b");
    chk("wrap.rd_data0", 32'(rd_data), 65535);
    step(1'b0, 1'b1, 1'b0, 1'b1, "wrap_pop");
    chk("wrap.rd_data1", 32'(rd_data), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, "wrap_push");
    chk("wrap.level", 32'(level), 2);

    // Async reset mid-cycle with entries queued
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.level", 32'(level), 0);
    chk("async_rst.rd_valid", 32'(rd_valid), 0);
    chk("async_rst.overflow", 32'(overflow), 0);
    chk("async_rst.event_count", 32'(event_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bit d, r, c;
      d = ($urandom_range(0, 1) == 1);
      r = (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 99) == 0);
      step(d, r, c, 1'b1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
